// File: rtl/keypad_multitap_ctrl_pkg.sv
// Shared types and key-decoding helpers for the multi-tap keypad controller.
// Key codes, FSM states, the matrix position decoder and the letter-set lookup.
package keypad_multitap_ctrl_pkg;

    typedef enum logic [4:0] {
        K0, K1, K2, K3, K4, K5, K6, K7, K8, K9,
        KA, KB, KC, KD, KSTAR, KHASH, KNONE
    } key_code_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TAP,
        ST_LOCKED,
        ST_END
    } state_t;

    // bit3 is index 0, matching the row/column numbering on the pins
    function automatic logic [1:0] onehot_index(input logic [3:0] oh);
        case (oh)
            4'b1000: return 2'd0;
            4'b0100: return 2'd1;
            4'b0010: return 2'd2;
            4'b0001: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic single_bit(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    function automatic key_code_t decode_key(input logic [1:0] row, input logic [1:0] col);
        case ({row, col})
            4'd0:    return K1;
            4'd1:    return K2;
            4'd2:    return K3;
            4'd3:    return KA;
            4'd4:    return K4;
            4'd5:    return K5;
            4'd6:    return K6;
            4'd7:    return KB;
            4'd8:    return K7;
            4'd9:    return K8;
            4'd10:   return K9;
            4'd11:   return KC;
            4'd12:   return KSTAR;
            4'd13:   return K0;
            4'd14:   return KHASH;
            4'd15:   return KD;
            default: return KNONE;
        endcase
    endfunction

    function automatic logic [7:0] set_base(input key_code_t k);
        case (k)
            K2:      return 8'd65;
            K3:      return 8'd68;
            K4:      return 8'd71;
            K5:      return 8'd74;
            K6:      return 8'd77;
            K7:      return 8'd80;
            K8:      return 8'd84;
            K9:      return 8'd87;
            default: return 8'd0;
        endcase
    endfunction

    function automatic logic [2:0] set_size(input key_code_t k);
        case (k)
            K2, K3, K4, K5, K6, K8: return 3'd3;
            K7, K9:                 return 3'd4;
            default:                return 3'd0;
        endcase
    endfunction

    function automatic logic is_letter_key(input key_code_t k);
        return set_size(k) != 3'd0;
    endfunction

endpackage

// File: rtl/keypad_multitap_ctrl_scanner.sv
// Column scanner and debouncer: rotates the column drive, freezes on a key,
// and emits one strobe per debounced single-row press plus a release pulse.
module keypad_multitap_ctrl_scanner
    import keypad_multitap_ctrl_pkg::*;
#(
    parameter int SCAN_DIV        = 4,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic      clk,
    input  logic      nRst,
    input  logic [3:0] read_row,
    output logic [3:0] scan_col,
    output logic      key_strobe,
    output logic      key_release,
    output key_code_t key_code
);

    localparam int DW = $clog2(SCAN_DIV + 1);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [3:0]    scan_col_r, scan_col_nxt_s;
    logic [DW-1:0] div_cnt_r, div_cnt_nxt_s;
    logic [CW-1:0] deb_cnt_r, deb_cnt_nxt_s;
    logic [3:0]    last_row_r;
    logic          held_r, held_nxt_s;
    logic          strobe_r, strobe_nxt_s;
    logic          release_r, release_nxt_s;
    key_code_t     code_r, code_nxt_s;
    logic          same_s, stable_evt_s, rotate_s;

    // Debounce counting, press/release qualification and column rotation
    always_comb begin
        same_s = (read_row == last_row_r);
        if (!same_s) begin
            deb_cnt_nxt_s = CW'(1);
        end else if (deb_cnt_r != CW'(DEBOUNCE_CYCLES)) begin
            deb_cnt_nxt_s = deb_cnt_r + CW'(1);
        end else begin
            deb_cnt_nxt_s = deb_cnt_r;
        end
        // fires once, on the cycle the pattern first reaches full stability
        stable_evt_s  = (deb_cnt_nxt_s == CW'(DEBOUNCE_CYCLES)) &&
                        !(same_s && (deb_cnt_r == CW'(DEBOUNCE_CYCLES)));
        strobe_nxt_s  = stable_evt_s && single_bit(read_row) && !held_r;
        release_nxt_s = stable_evt_s && (read_row == 4'd0) && held_r;

        if (strobe_nxt_s) begin
            held_nxt_s = 1'b1;
        end else if (release_nxt_s) begin
            held_nxt_s = 1'b0;
        end else begin
            held_nxt_s = held_r;
        end

        if (strobe_nxt_s) begin
            code_nxt_s = decode_key(onehot_index(read_row), onehot_index(scan_col_r));
        end else begin
            code_nxt_s = code_r;
        end

        // column stays put while any row is seen or a press awaits its release
        rotate_s      = (read_row == 4'd0) && !held_r;
        scan_col_nxt_s = scan_col_r;
        div_cnt_nxt_s  = DW'(0);
        if (!single_bit(scan_col_r)) begin
            scan_col_nxt_s = 4'b1000;
        end else if (rotate_s) begin
            if (div_cnt_r == DW'(SCAN_DIV - 1)) begin
                scan_col_nxt_s = {scan_col_r[0], scan_col_r[3:1]};
            end else begin
                div_cnt_nxt_s = div_cnt_r + DW'(1);
            end
        end else begin
            div_cnt_nxt_s = DW'(0);
        end
    end

    // Scanner state registers
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            scan_col_r <= 4'b1000;
            div_cnt_r  <= DW'(0);
            deb_cnt_r  <= CW'(0);
            last_row_r <= 4'd0;
            held_r     <= 1'b0;
            strobe_r   <= 1'b0;
            release_r  <= 1'b0;
            code_r     <= KNONE;
        end else begin
            scan_col_r <= scan_col_nxt_s;
            div_cnt_r  <= div_cnt_nxt_s;
            deb_cnt_r  <= deb_cnt_nxt_s;
            last_row_r <= read_row;
            held_r     <= held_nxt_s;
            strobe_r   <= strobe_nxt_s;
            release_r  <= release_nxt_s;
            code_r     <= code_nxt_s;
        end
    end

    assign scan_col    = scan_col_r;
    assign key_strobe  = strobe_r;
    assign key_release = release_r;
    assign key_code    = code_r;

endmodule

// File: rtl/keypad_multitap_ctrl.sv
// Multi-tap keypad controller: turns debounced key strobes into ASCII letters,
// with tap cycling, idle-timeout locking, submit/clear and a sticky game end.
module keypad_multitap_ctrl
    import keypad_multitap_ctrl_pkg::*;
#(
    parameter int SCAN_DIV        = 4,
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int TAP_TIMEOUT     = 200
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic [3:0] read_row,
    output logic [3:0] scan_col,
    output logic [7:0] data,
    output logic       ready,
    output logic       game_end,
    output logic       toggle_state
);

    localparam int TW = (TAP_TIMEOUT > 0) ? $clog2(TAP_TIMEOUT + 1) : 1;

    logic      key_strobe_s, key_release_s;
    key_code_t key_code_s;

    state_t        state_r, state_nxt_s;
    logic [1:0]    idx_r, idx_nxt_s, idx_inc_s;
    key_code_t     key_r, key_nxt_s;
    logic [TW-1:0] tmo_cnt_r, tmo_cnt_nxt_s;
    logic          tmo_run_r, tmo_run_nxt_s;
    logic [7:0]    data_r, data_nxt_s;
    logic          ready_r, ready_nxt_s;
    logic          game_end_r, game_end_nxt_s;
    logic          toggle_r, toggle_nxt_s;

    keypad_multitap_ctrl_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_scanner (
        .clk        (clk),
        .nRst       (nRst),
        .read_row   (read_row),
        .scan_col   (scan_col),
        .key_strobe (key_strobe_s),
        .key_release(key_release_s),
        .key_code   (key_code_s)
    );

    // Multi-tap next-state, letter, timeout and output computation
    always_comb begin
        state_nxt_s    = state_r;
        idx_nxt_s      = idx_r;
        key_nxt_s      = key_r;
        data_nxt_s     = data_r;
        ready_nxt_s    = 1'b0;
        game_end_nxt_s = game_end_r;
        tmo_run_nxt_s  = 1'b0;
        tmo_cnt_nxt_s  = TW'(0);
        idx_inc_s      = (({1'b0, idx_r} + 3'd1) >= set_size(key_r)) ? 2'd0 : (idx_r + 2'd1);

        case (state_r)
            ST_IDLE: begin
                data_nxt_s = 8'd0;
                if (key_strobe_s && (key_code_s == KD)) begin
                    state_nxt_s    = ST_END;
                    game_end_nxt_s = 1'b1;
                end else if (key_strobe_s && is_letter_key(key_code_s)) begin
                    state_nxt_s = ST_TAP;
                    idx_nxt_s   = 2'd0;
                    key_nxt_s   = key_code_s;
                    data_nxt_s  = set_base(key_code_s);
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_TAP, ST_LOCKED: begin
                if (key_strobe_s) begin
                    if (key_code_s == KD) begin
                        state_nxt_s    = ST_END;
                        data_nxt_s     = 8'd0;
                        game_end_nxt_s = 1'b1;
                    end else if (is_letter_key(key_code_s)) begin
                        state_nxt_s = ST_TAP;
                        if ((state_r == ST_TAP) && (key_code_s == key_r)) begin
                            idx_nxt_s = idx_inc_s;
                        end else begin
                            idx_nxt_s = 2'd0;
                        end
                        key_nxt_s  = key_code_s;
                        data_nxt_s = set_base(key_code_s) + {6'd0, idx_nxt_s};
                    end else if (key_code_s == KHASH) begin
                        // letter stays on data for the ready cycle, IDLE clears it next
                        ready_nxt_s = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else if (key_code_s == KSTAR) begin
                        data_nxt_s  = 8'd0;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = state_r;
                    end
                end else if (state_r == ST_TAP) begin
                    if (key_release_s) begin
                        tmo_run_nxt_s = 1'b1;
                        tmo_cnt_nxt_s = TW'(0);
                    end else if (tmo_run_r) begin
                        tmo_run_nxt_s = 1'b1;
                        if (tmo_cnt_r == TW'(TAP_TIMEOUT)) begin
                            tmo_cnt_nxt_s = tmo_cnt_r;
                        end else begin
                            tmo_cnt_nxt_s = tmo_cnt_r + TW'(1);
                        end
                        if ((TAP_TIMEOUT != 0) && (tmo_cnt_nxt_s == TW'(TAP_TIMEOUT))) begin
                            state_nxt_s = ST_LOCKED;
                        end else begin
                            state_nxt_s = ST_TAP;
                        end
                    end else begin
                        tmo_run_nxt_s = 1'b0;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_END: begin
                data_nxt_s     = 8'd0;
                game_end_nxt_s = 1'b1;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                data_nxt_s  = 8'd0;
            end
        endcase

        toggle_nxt_s = (state_nxt_s == ST_TAP);
    end

    // FSM, tap index, timeout and registered outputs
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_r    <= ST_IDLE;
            idx_r      <= 2'd0;
            key_r      <= KNONE;
            tmo_cnt_r  <= TW'(0);
            tmo_run_r  <= 1'b0;
            data_r     <= 8'd0;
            ready_r    <= 1'b0;
            game_end_r <= 1'b0;
            toggle_r   <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            idx_r      <= idx_nxt_s;
            key_r      <= key_nxt_s;
            tmo_cnt_r  <= tmo_cnt_nxt_s;
            tmo_run_r  <= tmo_run_nxt_s;
            data_r     <= data_nxt_s;
            ready_r    <= ready_nxt_s;
            game_end_r <= game_end_nxt_s;
            toggle_r   <= toggle_nxt_s;
        end
    end

    assign data         = data_r;
    assign ready        = ready_r;
    assign game_end     = game_end_r;
    assign toggle_state = toggle_r;

endmodule

// File: tb/tb_keypad_multitap_ctrl.sv
// Bench for keypad_multitap_ctrl: a matrix model driven from scan_col, a tap
// vector table, hand-written corner sequences and random taps against a letter model.
module tb_keypad_multitap_ctrl;

    logic       tb_clk;
    logic       rst_n;
    logic [3:0] read_row;
    logic [3:0] scan_col;
    logic [7:0] data;
    logic       ready;
    logic       game_end;
    logic       toggle_state;

    logic [15:0] pressed;

    int n_cmp  = 0;
    int n_fail = 0;

    int       upd_cnt = 0;
    int       rdy_cnt = 0;
    int       rdy_wide = 0;
    logic [7:0] rdy_data = 8'd0;
    logic [7:0] post_rdy_data = 8'hFF;
    logic [7:0] prev_data = 8'd0;
    logic       prev_rdy = 1'b0;

    keypad_multitap_ctrl #(
        .SCAN_DIV       (2),
        .DEBOUNCE_CYCLES(3),
        .TAP_TIMEOUT    (20)
    ) dut (
        .clk         (tb_clk),
        .nRst        (rst_n),
        .read_row    (read_row),
        .scan_col    (scan_col),
        .data        (data),
        .ready       (ready),
        .game_end    (game_end),
        .toggle_state(toggle_state)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    // Key matrix: key (r,c) shorts column c to row r; index r*4+c
    always_comb begin
        read_row = 4'd0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && scan_col[3-c]) read_row[3-r] = 1'b1;
            end
        end
    end

    // Output observer: data changes, ready pulses and the data following a ready
    always @(negedge tb_clk) begin
        prev_data <= data;
        prev_rdy  <= ready;
        if (rst_n && (data != prev_data)) upd_cnt <= upd_cnt + 1;
        if (rst_n && ready) begin
            rdy_cnt  <= rdy_cnt + 1;
            rdy_data <= data;
        end
        if (rst_n && ready && prev_rdy) rdy_wide <= rdy_wide + 1;
        if (rst_n && prev_rdy) post_rdy_data <= data;
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int kid(input string c);
        string keymap = "123A456B789C*0#D";
        for (int i = 0; i < 16; i++) begin
            if (keymap.getc(i) == c.getc(0)) return i;
        end
        return 0;
    endfunction

    function automatic byte key_char(input int k);
        string keymap = "123A456B789C*0#D";
        return keymap.getc(k);
    endfunction

    function automatic string letters_of(input byte d);
        case (d)
            8'h32:   return "ABC";
            8'h33:   return "DEF";
            8'h34:   return "GHI";
            8'h35:   return "JKL";
            8'h36:   return "MNO";
            8'h37:   return "PQRS";
            8'h38:   return "TUV";
            8'h39:   return "WXYZ";
            default: return "";
        endcase
    endfunction

    task automatic tap(input int k, input int hold, input int gap);
        pressed = 16'd1 << k;
        repeat (hold) @(negedge tb_clk);
        pressed = 16'd0;
        repeat (gap) @(negedge tb_clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge tb_clk);
        rst_n = 1'b1;
        @(negedge tb_clk);
    endtask

    typedef struct {
        int  key;
        byte exp_data;
        bit  exp_tog;
        int  exp_rdy;
        byte exp_rdy_data;
    } vec_t;
    vec_t vecs[$];

    function automatic void add_vec(input string k, input string d, input bit tog,
                                    input int rdy, input string rd);
        vec_t v;
        v.key          = kid(k);
        v.exp_data     = (d == "-") ? 8'd0 : d.getc(0);
        v.exp_tog      = tog;
        v.exp_rdy      = rdy;
        v.exp_rdy_data = (rd == "-") ? 8'd0 : rd.getc(0);
        vecs.push_back(v);
    endfunction

    // reference model of the letter logic: 0 idle, 1 tapping, 2 locked, 3 ended
    int   m_mode;
    byte  m_digit;
    int   m_idx;
    byte  m_data;
    bit   m_end;
    int   m_rdy;
    byte  m_rdy_data;

    function automatic void model_key(input byte ch);
        string s;
        if (m_mode == 3) return;
        s = letters_of(ch);
        if (ch == "D") begin
            m_mode = 3; m_data = 8'd0; m_end = 1'b1;
        end else if (s.len() != 0) begin
            if (m_mode == 1 && m_digit == ch) m_idx = (m_idx + 1) % s.len();
            else m_idx = 0;
            m_mode = 1; m_digit = ch; m_data = s.getc(m_idx);
        end else if (ch == "#" && (m_mode == 1 || m_mode == 2)) begin
            m_rdy++; m_rdy_data = m_data; m_data = 8'd0; m_mode = 0;
        end else if (ch == "*" && (m_mode == 1 || m_mode == 2)) begin
            m_data = 8'd0; m_mode = 0;
        end
    endfunction

    initial begin
        int u0, r0, k, gap;
        bit long_gap;
        pressed = 16'd0;
        rst_n   = 1'b0;

        // reset held with '2' pressed
        pressed = 16'd1 << kid("2");
        repeat (5) @(negedge tb_clk);
        check("rst_scan_col", scan_col, 4'b1000);
        check("rst_data", data, 0);
        check("rst_ready", ready, 0);
        check("rst_game_end", game_end, 0);
        check("rst_toggle", toggle_state, 0);

        // '2' still held at reset release, then held 50 cycles: one fresh press
        u0 = upd_cnt; r0 = rdy_cnt;
        rst_n = 1'b1;
        repeat (50) @(negedge tb_clk);
        pressed = 16'd0;
        repeat (8) @(negedge tb_clk);
        check("held_updates", upd_cnt - u0, 1);
        check("held_data", data, 8'h41);
        check("held_toggle", toggle_state, 1);
        check("held_no_ready", rdy_cnt - r0, 0);

        add_vec("3", "D", 1, 0, "-"); add_vec("3", "E", 1, 0, "-");
        add_vec("3", "F", 1, 0, "-"); add_vec("3", "D", 1, 0, "-");
        add_vec("7", "P", 1, 0, "-"); add_vec("7", "Q", 1, 0, "-");
        add_vec("7", "R", 1, 0, "-"); add_vec("7", "S", 1, 0, "-");
        add_vec("7", "P", 1, 0, "-"); add_vec("2", "A", 1, 0, "-");
        add_vec("#", "-", 0, 1, "A"); add_vec("5", "J", 1, 0, "-");
        add_vec("*", "-", 0, 0, "-"); add_vec("#", "-", 0, 0, "-");
        add_vec("1", "-", 0, 0, "-"); add_vec("6", "M", 1, 0, "-");
        add_vec("6", "N", 1, 0, "-"); add_vec("0", "N", 1, 0, "-");
        add_vec("6", "O", 1, 0, "-"); add_vec("9", "W", 1, 0, "-");
        add_vec("9", "X", 1, 0, "-"); add_vec("9", "Y", 1, 0, "-");
        add_vec("9", "Z", 1, 0, "-"); add_vec("9", "W", 1, 0, "-");
        add_vec("8", "T", 1, 0, "-"); add_vec("#", "-", 0, 1, "T");

        foreach (vecs[i]) begin
            r0 = rdy_cnt;
            tap(vecs[i].key, 20, 8);
            check($sformatf("vec%0d_data", i), data, vecs[i].exp_data);
            check($sformatf("vec%0d_toggle", i), toggle_state, vecs[i].exp_tog);
            check($sformatf("vec%0d_ready_cnt", i), rdy_cnt - r0, vecs[i].exp_rdy);
            if (vecs[i].exp_rdy != 0)
                check($sformatf("vec%0d_ready_data", i), rdy_data, vecs[i].exp_rdy_data);
        end

        // bouncy '5': on 2 / off 2 cycles never settles
        u0 = upd_cnt;
        for (int b = 0; b < 8; b++) begin
            pressed = 16'd1 << kid("5");
            repeat (2) @(negedge tb_clk);
            pressed = 16'd0;
            repeat (2) @(negedge tb_clk);
        end
        repeat (4) @(negedge tb_clk);
        check("bounce_no_update", upd_cnt - u0, 0);
        check("bounce_data", data, 0);
        tap(kid("5"), 20, 8);
        check("bounce_settled_data", data, 8'h4A);
        check("bounce_settled_updates", upd_cnt - u0, 1);
        tap(kid("*"), 20, 8);
        check("clear_data", data, 0);

        // timeout locks the letter, same key then starts a new letter
        tap(kid("4"), 20, 8);
        check("to_first_data", data, 8'h47);
        repeat (25) @(negedge tb_clk);
        check("to_locked_toggle", toggle_state, 0);
        check("to_locked_data", data, 8'h47);
        tap(kid("4"), 20, 8);
        check("to_relock_data", data, 8'h47);
        check("to_relock_toggle", toggle_state, 1);
        r0 = rdy_cnt;
        tap(kid("#"), 20, 8);
        check("submit_ready_cnt", rdy_cnt - r0, 1);
        check("submit_ready_data", rdy_data, 8'h47);
        check("submit_post_data", post_rdy_data, 0);
        check("submit_one_cycle", rdy_wide, 0);
        check("submit_data_idle", data, 0);

        // rows 0 and 1 together on column 1 ('2' and '5'): no strobe, frozen
        u0 = upd_cnt;
        pressed = (16'd1 << kid("2")) | (16'd1 << kid("5"));
        repeat (30) @(negedge tb_clk);
        check("ghost_frozen_col", scan_col, 4'b0100);
        check("ghost_data", data, 0);
        pressed = 16'd0;
        repeat (8) @(negedge tb_clk);
        check("ghost_no_update", upd_cnt - u0, 0);
        check("ghost_toggle", toggle_state, 0);

        // game end is sticky
        tap(kid("2"), 20, 8);
        check("pre_end_data", data, 8'h41);
        tap(kid("D"), 20, 8);
        check("end_flag", game_end, 1);
        check("end_data", data, 0);
        check("end_toggle", toggle_state, 0);
        tap(kid("2"), 20, 8);
        tap(kid("#"), 20, 8);
        check("end_sticky", game_end, 1);
        check("end_ignores_data", data, 0);

        // random taps against the letter model
        for (int round = 0; round < 3; round++) begin
            do_reset();
            m_mode = 0; m_digit = 8'd0; m_idx = 0; m_data = 8'd0; m_end = 1'b0;
            m_rdy = 0; m_rdy_data = 8'd0;
            r0 = rdy_cnt;
            for (int t = 0; t < 40; t++) begin
                k = $urandom_range(0, 15);
                if (k == 15 && $urandom_range(0, 3) != 0) k = $urandom_range(0, 14);
                long_gap = ($urandom_range(0, 4) == 0);
                gap = long_gap ? $urandom_range(40, 50) : $urandom_range(5, 8);
                tap(k, $urandom_range(16, 24), gap);
                model_key(key_char(k));
                if (long_gap && m_mode == 1) m_mode = 2;
                check($sformatf("rnd%0d_%0d_data", round, t), data, m_data);
                check($sformatf("rnd%0d_%0d_toggle", round, t), toggle_state, (m_mode == 1) ? 1 : 0);
                check($sformatf("rnd%0d_%0d_end", round, t), game_end, m_end);
                check($sformatf("rnd%0d_%0d_ready_cnt", round, t), rdy_cnt - r0, m_rdy);
                if (m_rdy != 0)
                    check($sformatf("rnd%0d_%0d_ready_data", round, t), rdy_data, m_rdy_data);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
